// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the 4-bit lab processor fetch/phase sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // Sequencer states. HALT parks the machine; FETCH/EXEC alternate while running.
  typedef enum logic [1:0] {
    HALT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam int OPC_W    = 4;
  localparam int OPR_W    = 4;
  localparam int DEC_IN_W = 7;

  // Bit positions inside decode_in = {opcode, c_flag, z_flag, phase}.
  localparam int DEC_PHASE   = 0;
  localparam int DEC_Z       = 1;
  localparam int DEC_C       = 2;
  localparam int DEC_OPC_LSB = 3;

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// Program counter: load / increment / hold, wrapping modulo 2^PC_W.
// Latency: new PC visible one edge after the request.
// Backpressure: none; i_en gates every update (held while the sequencer is halted).
// Ports: i_clk, i_reset (async, active-high), i_en, i_load, i_inc, i_load_addr -> o_pc.
module pc_counter
  import fetch_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic            i_load,
  input  logic            i_inc,
  input  logic [PC_W-1:0] i_load_addr,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc <= '0;
    end else if (i_en) begin
      // Load wins over increment; the add wraps naturally at PC_W bits.
      if (i_load) begin
        r_pc <= i_load_addr;
      end else if (i_inc) begin
        r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/execute phase sequencer: drives ROM address, latches IR, keeps carry/zero flags.
// Latency: one instruction per 2 cycles when running; a single step takes 3 edges HALT->FETCH->EXEC->HALT.
// Backpressure: none; run/step levels gate progress, HALT freezes PC, IR and flags.
// Ports: i_clk, i_reset, i_run, i_step, i_rom_data, i_pc_load, i_pc_inc, i_load_addr,
//        i_flags_we, i_c_in, i_z_in -> o_pc, o_operand, o_decode_in, o_phase, o_active.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W         = 12,
  parameter int RUN_ON_RESET = 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  input  logic                i_step,
  input  logic [7:0]          i_rom_data,
  input  logic                i_pc_load,
  input  logic                i_pc_inc,
  input  logic [PC_W-1:0]     i_load_addr,
  input  logic                i_flags_we,
  input  logic                i_c_in,
  input  logic                i_z_in,
  output logic [PC_W-1:0]     o_pc,
  output logic [OPR_W-1:0]    o_operand,
  output logic [DEC_IN_W-1:0] o_decode_in,
  output logic                o_phase,
  output logic                o_active
);

  localparam state_t RESET_STATE = (RUN_ON_RESET != 0) ? FETCH : HALT;

  state_t                   r_state;
  logic [OPC_W+OPR_W-1:0]   r_ir;
  logic                     r_c_flag;
  logic                     r_z_flag;
  logic                     r_step_pend;
  logic                     w_active;
  logic [DEC_IN_W-1:0]      w_decode_in;

  assign w_active = (r_state != HALT);

  pc_counter #(
    .PC_W (PC_W)
  ) u_pc (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (w_active),
    .i_load      (i_pc_load),
    .i_inc       (i_pc_inc),
    .i_load_addr (i_load_addr),
    .o_pc        (o_pc)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= RESET_STATE;
      r_ir        <= '0;
      r_c_flag    <= 1'b0;
      r_z_flag    <= 1'b0;
      r_step_pend <= 1'b0;
    end else begin
      case (r_state)
        HALT: begin
          // run dominates step, so step_pend is only set for a pure single-step.
          if (i_run) begin
            r_state <= FETCH;
          end else if (i_step) begin
            r_state     <= FETCH;
            r_step_pend <= 1'b1;
          end
        end
        FETCH: begin
          r_ir    <= i_rom_data;
          r_state <= EXEC;
        end
        EXEC: begin
          if (i_flags_we) begin
            r_c_flag <= i_c_in;
            r_z_flag <= i_z_in;
          end
          // run is only consulted here, so dropping it in FETCH still finishes the instruction.
          if (i_run && !r_step_pend) begin
            r_state <= FETCH;
          end else begin
            r_state     <= HALT;
            r_step_pend <= 1'b0;
          end
        end
        default: begin
          r_state <= RESET_STATE;
        end
      endcase
    end
  end

  // Registered IR and flags; only the phase bit is decoded from the state register.
  always_comb begin
    w_decode_in                              = '0;
    w_decode_in[DEC_OPC_LSB +: OPC_W]        = r_ir[OPC_W+OPR_W-1:OPR_W];
    w_decode_in[DEC_C]                       = r_c_flag;
    w_decode_in[DEC_Z]                       = r_z_flag;
    w_decode_in[DEC_PHASE]                   = (r_state == EXEC);
  end

  assign o_decode_in = w_decode_in;
  assign o_operand   = r_ir[OPR_W-1:0];
  assign o_phase     = (r_state == EXEC);
  assign o_active    = w_active;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        run, step, pc_load, pc_inc, flags_we, c_in, z_in;
  logic [11:0] load_addr;
  logic [7:0]  rom_data, rom_data_h;
  logic [11:0] pc, pc_h;
  logic [3:0]  operand, operand_h;
  logic [6:0]  decode_in, decode_in_h;
  logic        phase, phase_h, active, active_h;

  logic [7:0]  rom [0:4095];

  int n_vec;
  int n_err;

  assign rom_data   = rom[pc];
  assign rom_data_h = rom[pc_h];

  fetch_sequencer #(.PC_W(12), .RUN_ON_RESET(1)) u_dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_run       (run),
    .i_step      (step),
    .i_rom_data  (rom_data),
    .i_pc_load   (pc_load),
    .i_pc_inc    (pc_inc),
    .i_load_addr (load_addr),
    .i_flags_we  (flags_we),
    .i_c_in      (c_in),
    .i_z_in      (z_in),
    .o_pc        (pc),
    .o_operand   (operand),
    .o_decode_in (decode_in),
    .o_phase     (phase),
    .o_active    (active)
  );

  // Second instance leaving reset in HALT.
  fetch_sequencer #(.PC_W(12), .RUN_ON_RESET(0)) u_dut_h (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_run       (run),
    .i_step      (step),
    .i_rom_data  (rom_data_h),
    .i_pc_load   (pc_load),
    .i_pc_inc    (pc_inc),
    .i_load_addr (load_addr),
    .i_flags_we  (flags_we),
    .i_c_in      (c_in),
    .i_z_in      (z_in),
    .o_pc        (pc_h),
    .o_operand   (operand_h),
    .o_decode_in (decode_in_h),
    .o_phase     (phase_h),
    .o_active    (active_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        run, step, ld, inc, fwe, c, z;
    logic [11:0] addr;
    logic [11:0] e_pc;
    logic        e_phase, e_active;
    logic [6:0]  e_dec;
    logic [3:0]  e_opr;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string nm, input logic [11:0] epc, input logic eph,
                     input logic eact, input logic [6:0] edec, input logic [3:0] eopr);
    n_vec++;
    if (pc !== epc || phase !== eph || active !== eact || decode_in !== edec || operand !== eopr) begin
      n_err++;
      $display("FAIL %s: got pc=%h phase=%b active=%b decode_in=%b operand=%h; want pc=%h phase=%b active=%b decode_in=%b operand=%h",
               nm, pc, phase, active, decode_in, operand, epc, eph, eact, edec, eopr);
    end
  endtask

  task automatic chk_h(input string nm, input logic [11:0] epc, input logic eact);
    n_vec++;
    if (pc_h !== epc || active_h !== eact || phase_h !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got pc=%h active=%b phase=%b; want pc=%h active=%b phase=0",
               nm, pc_h, active_h, phase_h, epc, eact);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    rom[12'h000] = 8'h5A;
    rom[12'h001] = 8'h6B;
    rom[12'h002] = 8'h3C;
    rom[12'h003] = 8'h24;
    rom[12'h004] = 8'hF1;
    rom[12'h005] = 8'h71;
    rom[12'h007] = 8'hC3;
    rom[12'hFFF] = 8'hE2;

    //            run   step  ld    inc   fwe   c     z     addr     e_pc     ph    act   dec           opr
    vt[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h001,1'b1,1'b1,7'b0101_00_1,4'hA}; // FETCH 5A
    vt[1]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h002,1'b0,1'b1,7'b0101_00_0,4'hA};
    vt[2]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,12'h000, 12'h003,1'b1,1'b1,7'b0011_00_1,4'hC}; // flags_we in FETCH ignored
    vt[3]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,12'h000, 12'h004,1'b0,1'b1,7'b0011_10_0,4'hC}; // c=1 z=0 captured
    vt[4]  = '{1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,12'h123, 12'h123,1'b1,1'b1,7'b1111_10_1,4'h1}; // load beats inc
    vt[5]  = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,12'h000, 12'h124,1'b0,1'b1,7'b1111_01_0,4'h1};
    vt[6]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,12'hFFE, 12'hFFE,1'b1,1'b1,7'b0000_01_1,4'h0};
    vt[7]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'hFFF,1'b0,1'b1,7'b0000_01_0,4'h0};
    vt[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h000,1'b1,1'b1,7'b1110_01_1,4'h2}; // wrap FFF->000
    vt[9]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h001,1'b0,1'b1,7'b1110_01_0,4'h2};
    vt[10] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h002,1'b1,1'b1,7'b0110_01_1,4'hB}; // run drops in FETCH
    vt[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,12'h000, 12'h003,1'b0,1'b0,7'b0110_11_0,4'hB}; // EXEC completes -> HALT
    vt[12] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,12'h555, 12'h003,1'b0,1'b0,7'b0110_11_0,4'hB}; // HALT holds all
    vt[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h003,1'b0,1'b0,7'b0110_11_0,4'hB};
    vt[14] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h003,1'b0,1'b1,7'b0110_11_0,4'hB}; // step -> FETCH
    vt[15] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h004,1'b1,1'b1,7'b0010_11_1,4'h4};
    vt[16] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h005,1'b0,1'b0,7'b0010_11_0,4'h4}; // step in EXEC ignored
    vt[17] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h005,1'b0,1'b0,7'b0010_11_0,4'h4};
    vt[18] = '{1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h005,1'b0,1'b1,7'b0010_11_0,4'h4}; // run+step = run
    vt[19] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h006,1'b1,1'b1,7'b0111_11_1,4'h1};
    vt[20] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h007,1'b0,1'b1,7'b0111_11_0,4'h1}; // keeps running
    vt[21] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,12'h000, 12'h008,1'b1,1'b1,7'b1100_11_1,4'h3}; // now in EXEC

    reset = 1'b1; run = 1'b0; step = 1'b0; pc_load = 1'b0; pc_inc = 1'b0;
    flags_we = 1'b0; c_in = 1'b0; z_in = 1'b0; load_addr = 12'h000;
    #2;
    chk("reset_state", 12'h000, 1'b0, 1'b1, 7'b0000000, 4'h0);
    chk_h("reset_state_halt", 12'h000, 1'b0);
    #10 reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run = vt[i].run; step = vt[i].step; pc_load = vt[i].ld; pc_inc = vt[i].inc;
      flags_we = vt[i].fwe; c_in = vt[i].c; z_in = vt[i].z; load_addr = vt[i].addr;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_phase, vt[i].e_active, vt[i].e_dec, vt[i].e_opr);
    end

    // Asynchronous reset in the middle of an EXEC cycle, with a flag write and load pending.
    flags_we = 1'b1; c_in = 1'b0; z_in = 1'b0; pc_load = 1'b1; load_addr = 12'hABC;
    #2 reset = 1'b1;
    #1;
    chk("async_reset_mid_exec", 12'h000, 1'b0, 1'b1, 7'b0000000, 4'h0);
    chk_h("async_reset_halt_inst", 12'h000, 1'b0);
    #2;
    reset = 1'b0; run = 1'b0; step = 1'b0; pc_load = 1'b0; pc_inc = 1'b1; flags_we = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_fetch", 12'h001, 1'b1, 1'b1, 7'b0101_00_1, 4'hA);
    chk_h("post_reset_halt_holds", 12'h000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and phase sequencer for the 4-bit lab processor. It drives the program ROM address and latches the fetched byte into an instruction register. It keeps the carry/zero flag register and alternates fetch/execute phases. Its 7-bit `decode_in` output feeds the `decode` truth-table stage directly. `decode` returns PC and flag write controls, which this block consumes on the next edge.

## Interface
Parameters:
- `PC_W`, 12, program counter / ROM address width
- `RUN_ON_RESET`, 1, 1 = leave reset in FETCH (free-running); 0 = leave reset in HALT

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `run`  in  1  level; 1 = continuous execution
- `step`  in  1  single-cycle pulse; executes one full instruction when halted
- `rom_data`  in  8  program byte at `pc`, combinational ROM read; [7:4] opcode, [3:0] operand
- `pc_load`  in  1  from decode: load `load_addr` into PC
- `pc_inc`  in  1  from decode: increment PC
- `load_addr`  in  PC_W  jump target
- `flags_we`  in  1  from decode: capture ALU flags
- `c_in`, `z_in`  in  1 each  ALU carry / zero
- `pc`  out  PC_W  ROM address
- `operand`  out  4  IR[3:0]
- `decode_in`  out  7  {IR[7:4], c_flag, z_flag, phase} to decode
- `phase`  out  1  0 = fetch, 1 = execute
- `active`  out  1  1 in FETCH/EXEC; datapath gates all register writes with it

## Operation
- States: HALT, FETCH, EXEC. `phase` = (state==EXEC). `active` = (state!=HALT).
- HALT: when `run`=1, go to FETCH. When `step`=1, go to FETCH and set `step_pend`. Otherwise stay in HALT. PC, IR and flags hold.
- FETCH: capture IR <= `rom_data`. Go to EXEC. Apply PC update.
- EXEC: apply PC update and the flag update.
  - Next state is FETCH if `run`=1 and `step_pend`=0.
  - Otherwise next state is HALT, and `step_pend` clears.
- PC update happens in FETCH/EXEC only. `pc_load` has priority over `pc_inc`. With neither asserted, PC holds. PC increment wraps modulo 2^PC_W, so all-ones + 1 = 0.
- Flag update: when `flags_we`=1 in EXEC, set c_flag <= `c_in` and z_flag <= `z_in`. `flags_we` in FETCH or HALT is ignored.
- `pc_load`/`pc_inc` in HALT are ignored.
- `run` falling during FETCH: the instruction completes through EXEC, then the block goes to HALT.
- `step` while `run`=1 or while not in HALT: ignored.
- `run` and `step` both high in HALT: treat as run; `step_pend` stays 0.

## Timing
- Reset values: `pc`=0, IR=0, c_flag=0, z_flag=0, `step_pend`=0. `phase`=0. State is FETCH (`RUN_ON_RESET`=1) or HALT (`RUN_ON_RESET`=0). `active` follows the state.
- Reset asserted mid-EXEC clears all state asynchronously. No partial PC or flag write survives.
- One instruction takes 2 cycles (FETCH, EXEC) when running. A step from HALT takes 3 edges: HALT->FETCH->EXEC->HALT.
- `decode_in` and `operand` are registered values except the phase bit, which decodes from state. They are valid in the cycle after the FETCH edge and stable for the whole EXEC cycle.
- Inputs from decode are sampled on the edge that ends the current cycle. This is a combinational loop-free path: decode depends only on `decode_in`.
- `rom_data` must be valid by the FETCH-ending edge for the `pc` presented during FETCH.

## Structure
- `fetch_pkg`:
  - state enum {HALT, FETCH, EXEC}
  - constants OPC_W=4, OPR_W=4, DEC_IN_W=7
  - bit-position constants DEC_PHASE=0, DEC_Z=1, DEC_C=2, DEC_OPC_LSB=3
- Sub-module `pc_counter`: PC_W register with async reset, load/inc/hold priority and wrap. Everything else (FSM, IR, flags, step_pend) lives in `fetch_sequencer`.

## Test plan
- Reset with `RUN_ON_RESET`=1, `run`=1, ROM[0]=8'h5A, `pc_inc` high in every cycle -> `phase` toggles 0,1,0,1. After the first EXEC cycle, `decode_in`=7'b0101_00_1 and `operand`=4'hA. `pc` advances 2 per instruction.
- `pc`=12'hFFF with `pc_inc` -> `pc`=12'h000 next edge. `pc_load`=1 and `pc_inc`=1 together with `load_addr`=12'h123 -> `pc`=12'h123.
- `flags_we`=1, `c_in`=1, `z_in`=0 in EXEC -> `decode_in`[2:1]=2'b10. The same pulse during FETCH leaves the flags unchanged.
- `run`=0 from HALT, single `step` pulse -> exactly one FETCH and one EXEC, then HALT with `active`=0. A second `step` during EXEC is ignored.
- `run` dropped during FETCH -> EXEC completes, then HALT. `pc` and flags hold afterwards despite `pc_inc`=1.
- `reset` asserted mid-EXEC between edges -> `pc`, `decode_in`, `operand` and `phase` read 0 before the next clock edge.
